// File: rtl/manual_clk_gen.sv
// rtl/manual_clk_gen.sv - debounced single-step clock and mode toggle from two push buttons
// Optional STEP_AUTOREPEAT_EN: a held step button toggles manual_clk every REPEAT_CNT cycles.
module manual_clk_gen #(
  parameter logic [31:0] DEBOUNCE_CNT = 32'h000F4240,
  parameter logic [31:0] REPEAT_CNT   = 32'h00F42400
) (
  input  logic       raw_clk,
  input  logic       rst_n,
  input  logic       step_btn,
  input  logic       mode_btn,
  output logic       manual_clk,
  output logic       auto_en,
  output logic       step_pulse,
  output logic [7:0] step_cnt
);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  localparam logic [31:0] DB_MAX = (DEBOUNCE_CNT <= 32'd1) ? 32'd0 : DEBOUNCE_CNT - 32'd1;

  // Index 0 is the step button, index 1 the mode button.
  logic [1:0]  sync1_q, sync2_q;
  state_t      state_q [2];
  state_t      state_d [2];
  logic [31:0] cnt_q   [2];
  logic [31:0] cnt_d   [2];

  logic       manual_clk_q, manual_clk_d;
  logic       auto_en_q, auto_en_d;
  logic       step_pulse_q, step_pulse_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       step_rise, step_fall, mode_rise;

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [31:0] RP_MAX = (REPEAT_CNT <= 32'd1) ? 32'd1 : REPEAT_CNT - 32'd1;
  logic [31:0] rpt_q, rpt_d;
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LOW: if (sync2_q[i]) begin
          state_d[i] = S_RISE;
          cnt_d[i]   = '0;
        end
        S_RISE: begin
          if (!sync2_q[i])           state_d[i] = S_LOW;
          else if (cnt_q[i] == DB_MAX) state_d[i] = S_HIGH;
          else                       cnt_d[i] = cnt_q[i] + 32'd1;
        end
        S_HIGH: if (!sync2_q[i]) begin
          state_d[i] = S_FALL;
          cnt_d[i]   = '0;
        end
        S_FALL: begin
          if (sync2_q[i])            state_d[i] = S_HIGH;
          else if (cnt_q[i] == DB_MAX) state_d[i] = S_LOW;
          else                       cnt_d[i] = cnt_q[i] + 32'd1;
        end
        default: state_d[i] = S_LOW;
      endcase
    end
  end

  assign step_rise = (state_q[0] == S_RISE) && (state_d[0] == S_HIGH);
  assign step_fall = (state_q[0] == S_FALL) && (state_d[0] == S_LOW);
  assign mode_rise = (state_q[1] == S_RISE) && (state_d[1] == S_HIGH);

  always_comb begin
    manual_clk_d = manual_clk_q;
    step_pulse_d = 1'b0;
    step_cnt_d   = step_cnt_q;
    auto_en_d    = auto_en_q ^ mode_rise;
`ifdef STEP_AUTOREPEAT_EN
    // Counter runs only while the step debouncer sits in S_HIGH, so it restarts on every entry.
    rpt_d = '0;
    if (state_q[0] == S_HIGH) begin
      if (rpt_q == RP_MAX) begin
        manual_clk_d = ~manual_clk_q;
        if (!manual_clk_q) begin
          step_pulse_d = 1'b1;
          step_cnt_d   = step_cnt_q + 8'd1;
        end
      end else begin
        rpt_d = rpt_q + 32'd1;
      end
    end
`endif
    if (step_rise) begin
      manual_clk_d = 1'b1;
      step_pulse_d = 1'b1;
      step_cnt_d   = step_cnt_q + 8'd1;
    end
    if (step_fall) manual_clk_d = 1'b0;
  end

  always_ff @(posedge raw_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
      manual_clk_q <= 1'b0;
      auto_en_q    <= 1'b0;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q        <= '0;
`endif
    end else begin
      sync1_q <= {mode_btn, step_btn};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      manual_clk_q <= manual_clk_d;
      auto_en_q    <= auto_en_d;
      step_pulse_q <= step_pulse_d;
      step_cnt_q   <= step_cnt_d;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

  assign manual_clk = manual_clk_q;
  assign auto_en    = auto_en_q;
  assign step_pulse = step_pulse_q;
  assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_manual_clk_gen.sv
// tb/tb_manual_clk_gen.sv - self-checking bench for manual_clk_gen (DEBOUNCE_CNT=4, REPEAT_CNT=8)
module tb_manual_clk_gen;

  logic       raw_clk = 1'b0;
  logic       rst_n;
  logic       step_btn;
  logic       mode_btn;
  logic       manual_clk;
  logic       auto_en;
  logic       step_pulse;
  logic [7:0] step_cnt;

  manual_clk_gen #(.DEBOUNCE_CNT(32'd4), .REPEAT_CNT(32'd8)) dut (
    .raw_clk    (raw_clk),
    .rst_n      (rst_n),
    .step_btn   (step_btn),
    .mode_btn   (mode_btn),
    .manual_clk (manual_clk),
    .auto_en    (auto_en),
    .step_pulse (step_pulse),
    .step_cnt   (step_cnt)
  );

  always #5 raw_clk = ~raw_clk;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  always @(negedge raw_clk) if (step_pulse) pulse_cnt++;

  typedef struct {
    string name;
    int    step_hold;
    int    mode_hold;
    bit    bounce;
    int    exp_steps;
    bit    exp_toggle;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] step_cnt;
    logic       auto_en;
    int         pulses;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_step_cnt = 8'd0;
  logic       m_auto = 1'b0;
  int         m_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic sb_push(input string name, input int steps, input bit toggle);
    exp_t e;
    m_step_cnt = m_step_cnt + steps[7:0];
    m_pulses   = m_pulses + steps;
    m_auto     = m_auto ^ toggle;
    e.name = name; e.step_cnt = m_step_cnt; e.auto_en = m_auto; e.pulses = m_pulses;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_step_cnt"}, {24'd0, step_cnt}, {24'd0, e.step_cnt});
      check({e.name, "_auto_en"}, {31'd0, auto_en}, {31'd0, e.auto_en});
      check({e.name, "_pulses"}, pulse_cnt, e.pulses);
      check({e.name, "_manual_idle"}, {31'd0, manual_clk}, 32'd0);
    end
  endtask

  // Expected manual_clk after edge k for a press first sampled at edge 1 and held for `hold` edges.
  function automatic bit exp_manual(input int k, input int hold);
`ifdef STEP_AUTOREPEAT_EN
    int last;
`endif
    if (k < 7 || k >= hold + 7) return 1'b0;
`ifdef STEP_AUTOREPEAT_EN
    last = (k < hold + 3) ? k : hold + 3;
    return ((last - 7) / 8) % 2 == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic hold_seq(input string name, input int hold);
    int steps;
    steps = 0;
    for (int k = 1; k <= hold + 10; k++)
      if (exp_manual(k, hold) && !exp_manual(k - 1, hold)) steps++;
    sb_push(name, steps, 1'b0);
    step_btn = 1'b1;
    for (int k = 1; k <= hold + 10; k++) begin
      cyc();
      check({name, "_manual_clk"}, {31'd0, manual_clk}, {31'd0, exp_manual(k, hold)});
      check({name, "_step_pulse"}, {31'd0, step_pulse},
            {31'd0, exp_manual(k, hold) && !exp_manual(k - 1, hold)});
      if (k == hold) step_btn = 1'b0;
    end
    sb_pop();
  endtask

  task automatic apply_vec(input vec_t v);
    int maxh;
    sb_push(v.name, v.exp_steps, v.exp_toggle);
    if (v.bounce) begin
      for (int i = 0; i < 4; i++) begin
        step_btn = (i % 2 == 0);
        cyc();
        check({v.name, "_manual_clk"}, {31'd0, manual_clk}, 32'd0);
      end
      step_btn = 1'b0;
    end else begin
      maxh = (v.step_hold > v.mode_hold) ? v.step_hold : v.mode_hold;
      step_btn = (v.step_hold > 0);
      mode_btn = (v.mode_hold > 0);
      for (int i = 1; i <= maxh; i++) begin
        cyc();
        if (i == v.step_hold) step_btn = 1'b0;
        if (i == v.mode_hold) mode_btn = 1'b0;
      end
    end
    repeat (12) cyc();
    sb_pop();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"clean_hold10",      10, 0, 1'b0, 1, 1'b0};
    vecs[1] = '{"bounce_1010",        0, 0, 1'b1, 0, 1'b0};
    vecs[2] = '{"step_hold4_reject",  4, 0, 1'b0, 0, 1'b0};
    vecs[3] = '{"step_hold5_accept",  5, 0, 1'b0, 1, 1'b0};
    vecs[4] = '{"mode_press1",        0, 8, 1'b0, 0, 1'b1};
    vecs[5] = '{"mode_press2",        0, 8, 1'b0, 0, 1'b1};
    vecs[6] = '{"mode_press3",        0, 8, 1'b0, 0, 1'b1};
    vecs[7] = '{"mode_hold4_reject",  0, 4, 1'b0, 0, 1'b0};
    vecs[8] = '{"both_simultaneous",  8, 8, 1'b0, 1, 1'b1};
    vecs[9] = '{"mode_press4",        0, 6, 1'b0, 0, 1'b1};

    rst_n = 1'b0;
    step_btn = 1'b0;
    mode_btn = 1'b0;
    repeat (3) cyc();
    check("reset_manual_clk", {31'd0, manual_clk}, 32'd0);
    check("reset_auto_en", {31'd0, auto_en}, 32'd0);
    check("reset_step_pulse", {31'd0, step_pulse}, 32'd0);
    check("reset_step_cnt", {24'd0, step_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    hold_seq("press_hold20", 20);

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    hold_seq("press_hold47", 47);

    begin
      logic [7:0] start_cnt;
      start_cnt = step_cnt;
      sb_push("wrap256", 256, 1'b0);
      for (int i = 0; i < 256; i++) begin
        step_btn = 1'b1;
        repeat (6) cyc();
        step_btn = 1'b0;
        repeat (10) cyc();
        if (i == 254) check("wrap_at_255", {24'd0, step_cnt}, {24'd0, start_cnt + 8'd255});
      end
      sb_pop();
    end

    // Reset while the step debouncer is in S_RISE with the button still held.
    step_btn = 1'b1;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    check("rst_mid_manual_clk", {31'd0, manual_clk}, 32'd0);
    check("rst_mid_auto_en", {31'd0, auto_en}, 32'd0);
    check("rst_mid_step_pulse", {31'd0, step_pulse}, 32'd0);
    check("rst_mid_step_cnt", {24'd0, step_cnt}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    m_step_cnt = 8'd0;
    m_auto = 1'b0;
    sb_push("after_reset", 1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("after_reset_manual_clk", {31'd0, manual_clk}, {31'd0, k >= 7});
      check("after_reset_step_pulse", {31'd0, step_pulse}, {31'd0, k == 7});
    end
    step_btn = 1'b0;
    repeat (12) cyc();
    sb_pop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
